// File: rtl/fifo_led_reader.sv
// fifo_led_reader: drains the project FIFO one word at a time and shows each
// word on the board LEDs for HOLD_CYCLES clock cycles before popping the next.
// The pop request and busy flag are decoded straight from the state register;
// every other output comes from its own register.
module fifo_led_reader #(
  parameter int unsigned DATA_WIDTH     = 6,
  parameter logic [31:0] HOLD_CYCLES    = 32'd27000000,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic                  clkIn,
  input  logic                  sysResetIn,
  input  logic                  startIn,
  input  logic                  fifoEmptyIn,
  input  logic [DATA_WIDTH-1:0] fifoDataIn,
  output logic                  fifoReadEnableOut,
  output logic [DATA_WIDTH-1:0] ledOut,
  output logic                  validOut,
  output logic                  busyOut,
  output logic [7:0]            popCountOut
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Counter reload value: the capture cycle's successor is the first of
  // HOLD_CYCLES display cycles, ending when the counter reaches zero.
  localparam logic [31:0] HOLD_LOAD = HOLD_CYCLES - 32'd1;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic                    valid_q;
  logic [7:0]              pop_cnt_q;
  logic [31:0]             hold_cnt_q;
  logic                    can_pop;

  // A pop may only be issued when running and the FIFO is known non-empty.
  assign can_pop = startIn & ~fifoEmptyIn;

  // Sequencer: pop, wait out the read latency, capture, then dwell.
  always_ff @(posedge clkIn or negedge sysResetIn) begin
    if (!sysResetIn) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      valid_q    <= 1'b0;
      pop_cnt_q  <= 8'd0;
      hold_cnt_q <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (can_pop) begin
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          pop_cnt_q <= pop_cnt_q + 8'd1;
          if (READ_LATENCY == 0) begin
            // Zero-latency FIFO: data is already valid alongside the request.
            word_q     <= fifoDataIn;
            valid_q    <= 1'b1;
            hold_cnt_q <= HOLD_LOAD;
            state_q    <= ST_HOLD;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          word_q     <= fifoDataIn;
          valid_q    <= 1'b1;
          hold_cnt_q <= HOLD_LOAD;
          state_q    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt_q == 32'd0) begin
            // Dwell finished: chain straight into the next pop if possible,
            // otherwise park in IDLE with the last word still displayed.
            state_q <= can_pop ? ST_REQ : ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifoReadEnableOut = (state_q == ST_REQ);
  assign busyOut           = (state_q != ST_IDLE);
  assign validOut          = valid_q;
  assign popCountOut       = pop_cnt_q;

  // LED polarity is fixed at build time; reset word 0 means all LEDs off.
  generate
    if (LED_ACTIVE_LOW) begin : g_led_low
      assign ledOut = ~word_q;
    end else begin : g_led_high
      assign ledOut = word_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_led_reader.sv
// Directed bench for fifo_led_reader: a small FIFO model feeds the main
// instance (HOLD_CYCLES=4, READ_LATENCY=1); two extra instances with
// HOLD_CYCLES=1 exercise pop-count wrap and back-to-back spacing.
module tb_fifo_led_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       fifo_empty;
  logic [5:0] fifo_data;
  logic       rd_en;
  logic [5:0] led;
  logic       valid;
  logic       busy;
  logic [7:0] pop_cnt;

  logic       start_w1, start_w0;
  logic [5:0] data_w1, data_w0;
  logic       rd_en_w1, rd_en_w0;
  logic [5:0] led_w1, led_w0;
  logic       valid_w1, valid_w0;
  logic       busy_w1, busy_w0;
  logic [7:0] pop_w1, pop_w0;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model for the main instance (one-cycle read latency)
  logic [5:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en && (wr_ptr != rd_ptr)) begin
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  fifo_led_reader #(.DATA_WIDTH(6), .HOLD_CYCLES(32'd4), .READ_LATENCY(1), .LED_ACTIVE_LOW(1'b1)) dut (
    .clkIn(clk), .sysResetIn(rst_n), .startIn(start), .fifoEmptyIn(fifo_empty),
    .fifoDataIn(fifo_data), .fifoReadEnableOut(rd_en), .ledOut(led),
    .validOut(valid), .busyOut(busy), .popCountOut(pop_cnt)
  );

  fifo_led_reader #(.DATA_WIDTH(6), .HOLD_CYCLES(32'd1), .READ_LATENCY(1), .LED_ACTIVE_LOW(1'b1)) dut_w1 (
    .clkIn(clk), .sysResetIn(rst_n), .startIn(start_w1), .fifoEmptyIn(1'b0),
    .fifoDataIn(data_w1), .fifoReadEnableOut(rd_en_w1), .ledOut(led_w1),
    .validOut(valid_w1), .busyOut(busy_w1), .popCountOut(pop_w1)
  );

  fifo_led_reader #(.DATA_WIDTH(6), .HOLD_CYCLES(32'd1), .READ_LATENCY(0), .LED_ACTIVE_LOW(1'b1)) dut_w0 (
    .clkIn(clk), .sysResetIn(rst_n), .startIn(start_w0), .fifoEmptyIn(1'b0),
    .fifoDataIn(data_w0), .fifoReadEnableOut(rd_en_w0), .ledOut(led_w0),
    .validOut(valid_w0), .busyOut(busy_w0), .popCountOut(pop_w0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pops, vcnt, cyc, last_pop, extra;
    int p1, p0, last1, last0, bad1, bad0;
    logic [5:0] shown [0:7];

    rst_n = 1'b0; start = 1'b0; start_w1 = 1'b0; start_w0 = 1'b0;
    fifo_data = 6'd0; data_w1 = 6'b100101; data_w0 = 6'b001011;

    // 1. reset values
    repeat (3) step();
    chk("rst_led", led, 6'b111111);
    chk("rst_busy", busy, 0);
    chk("rst_popcnt", pop_cnt, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_valid", valid, 0);
    rst_n = 1'b1;
    step();

    // 2. single word
    push(6'b000001);
    start = 1'b1;
    step();
    chk("t2_req", rd_en, 1);
    chk("t2_busy", busy, 1);
    start = 1'b0;
    step();
    chk("t2_req_once", rd_en, 0);
    chk("t2_led_before", led, 6'b111111);
    step();
    chk("t2_led", led, 6'b111110);
    chk("t2_valid", valid, 1);
    step();
    chk("t2_valid_pulse", valid, 0);
    step(); step();
    chk("t2_led_held", led, 6'b111110);
    chk("t2_busy_hold", busy, 1);
    step();
    chk("t2_idle", busy, 0);
    chk("t2_popcnt", pop_cnt, 1);
    chk("t2_led_keep", led, 6'b111110);
    chk("t2_rden_idle", rd_en, 0);

    rst_n = 1'b0; step(); rst_n = 1'b1; step();

    // 3. three words with start held high
    push(6'b101010); push(6'b010101); push(6'b000111);
    start = 1'b1;
    pops = 0; vcnt = 0; last_pop = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rd_en) begin
        pops++;
        if (pops > 1) chk("t3_spacing", i - last_pop, 6);
        last_pop = i;
      end
      if (valid && vcnt < 8) begin
        shown[vcnt] = led;
        vcnt++;
      end
    end
    chk("t3_pops", pops, 3);
    chk("t3_valids", vcnt, 3);
    chk("t3_led0", shown[0], 6'b010101);
    chk("t3_led1", shown[1], 6'b101010);
    chk("t3_led2", shown[2], 6'b111000);
    chk("t3_popcnt", pop_cnt, 3);
    chk("t3_idle", busy, 0);
    start = 1'b0;

    // 4. stop mid-hold with two words still queued
    push(6'b110011); push(6'b001100); push(6'b011110);
    start = 1'b1;
    step();
    chk("t4_req", rd_en, 1);
    step(); step();
    chk("t4_valid", valid, 1);
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rd_en) extra++;
    end
    chk("t4_no_pop", extra, 0);
    chk("t4_idle", busy, 0);
    chk("t4_not_empty", fifo_empty, 0);
    chk("t4_popcnt", pop_cnt, 4);
    chk("t4_led", led, 6'b001100);

    // 5. async reset in the WAIT cycle
    start = 1'b1;
    step();
    chk("t5_req", rd_en, 1);
    step();
    chk("t5_wait_busy", busy, 1);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_popcnt", pop_cnt, 0);
    chk("t5_async_led", led, 6'b111111);
    chk("t5_async_rden", rd_en, 0);
    chk("t5_async_valid", valid, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t5_idle", busy, 0);
    chk("t5_led", led, 6'b111111);

    // 6. wrap and back-to-back throughput, HOLD_CYCLES=1
    start_w1 = 1'b1; start_w0 = 1'b1;
    p1 = 0; p0 = 0; last1 = 0; last0 = 0; bad1 = 0; bad0 = 0; cyc = 0;
    while ((p1 < 257 || p0 < 257) && cyc < 1500) begin
      step();
      if (rd_en_w1) begin
        p1++;
        if (p1 > 1 && (cyc - last1) != 3) bad1++;
        last1 = cyc;
        if (p1 == 257) start_w1 = 1'b0;
      end
      if (rd_en_w0) begin
        p0++;
        if (p0 > 1 && (cyc - last0) != 2) bad0++;
        last0 = cyc;
        if (p0 == 257) start_w0 = 1'b0;
      end
      cyc++;
    end
    chk("t6_pops_l1", p1, 257);
    chk("t6_pops_l0", p0, 257);
    chk("t6_spacing_l1", bad1, 0);
    chk("t6_spacing_l0", bad0, 0);
    repeat (5) step();
    chk("t6_wrap_l1", pop_w1, 1);
    chk("t6_wrap_l0", pop_w0, 1);
    chk("t6_idle_l1", busy_w1, 0);
    chk("t6_idle_l0", busy_w0, 0);
    chk("t6_led_l1", led_w1, 6'b011010);
    chk("t6_led_l0", led_w0, 6'b110100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
